// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and metadata layout for the execute-stage ALU.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_ADDU = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_SUBU = 3'd3;
  localparam logic [2:0] ALU_SLT  = 3'd4;
  localparam logic [2:0] ALU_SLTU = 3'd5;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_EXC = 1'b1
  } state_t;

  // Width-independent part of the EX/MEM register.
  typedef struct packed {
    logic        exc;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] pc;
  } meta_t;

  function automatic logic is_trapping(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// Combinational add/sub/slt core: result, carry/borrow and signed overflow.
// Zero latency, no flow control; opcodes 6-7 fall through to ADDU.
module alu_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           add_ovf;
  logic           sub_ovf;

  // Zero-extended so bit WIDTH is carry for add and borrow for subtract.
  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = {1'b0, a} - {1'b0, b};
  assign add_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
  assign sub_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);

  always_comb begin
    result = sum[MSB:0];
    carry  = sum[WIDTH];
    ovf    = add_ovf;
    case (op)
      ALU_SUB, ALU_SUBU: begin
        result = diff[MSB:0];
        carry  = diff[WIDTH];
        ovf    = sub_ovf;
      end
      ALU_SLT: begin
        result = {{(WIDTH-1){1'b0}}, diff[MSB] ^ sub_ovf};
        carry  = diff[WIDTH];
        ovf    = 1'b0;
      end
      ALU_SLTU: begin
        result = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
        carry  = diff[WIDTH];
        ovf    = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ex_stage.sv
// Execute stage: ALU plus single-entry EX/MEM register; 1-cycle latency, 1 op/cycle.
// Holds output while out_ready is low; stalls input in EXC until exc_ack.
module alu_ex_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [31:0]      in_pc,
  input  logic [4:0]       in_rd,
  input  logic             in_wen,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_exc,
  output logic [4:0]       out_rd,
  output logic             out_wen,
  output logic [31:0]      out_pc,
  output logic             exc_req,
  output logic [31:0]      exc_epc,
  input  logic             exc_ack
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;
  logic             trap;
  logic             accept;
  meta_t            meta_q;

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .op     (in_op),
    .a      (in_a),
    .b      (in_b),
    .result (alu_res),
    .carry  (alu_carry),
    .ovf    (alu_ovf)
  );

  assign trap   = is_trapping(in_op) && alu_ovf;
  assign accept = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    exc_req   = 1'b0;
    case (state)
      ST_RUN: begin
        in_ready = !out_valid || out_ready;
        if (in_valid && in_ready && !flush && trap) state_nxt = ST_EXC;
      end
      ST_EXC: begin
        exc_req = 1'b1;
        if (exc_ack) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_carry  <= 1'b0;
      out_ovf    <= 1'b0;
      meta_q     <= '0;
      exc_epc    <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_result <= alu_res;
      out_carry  <= alu_carry;
      out_ovf    <= alu_ovf;
      // A trapped op must never reach the register file.
      meta_q     <= '{exc: trap, wen: in_wen && !trap, rd: in_rd, pc: in_pc};
      if (trap) exc_epc <= in_pc;
    end else if (flush || out_ready) begin
      out_valid  <= 1'b0;
      meta_q.exc <= 1'b0;
      meta_q.wen <= 1'b0;
    end
  end

  assign out_exc = meta_q.exc;
  assign out_wen = meta_q.wen;
  assign out_rd  = meta_q.rd;
  assign out_pc  = meta_q.pc;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Self-checking bench for alu_ex_stage: directed corner cases plus a randomized run.
module tb_alu_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_wen, flush;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b, in_pc;
  logic [4:0]  in_rd;
  logic        out_valid, out_ready, out_carry, out_ovf, out_exc, out_wen;
  logic [31:0] out_result, out_pc, exc_epc;
  logic [4:0]  out_rd;
  logic        exc_req, exc_ack;

  int errors = 0;
  int checks = 0;

  alu_ex_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_pc(in_pc), .in_rd(in_rd), .in_wen(in_wen),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_ovf(out_ovf), .out_exc(out_exc),
    .out_rd(out_rd), .out_wen(out_wen), .out_pc(out_pc),
    .exc_req(exc_req), .exc_epc(exc_epc), .exc_ack(exc_ack)
  );

  always #5 clk = ~clk;

  // {valid, result, carry, ovf, exc, wen}
  function automatic logic [36:0] obs();
    return {out_valid, out_result, out_carry, out_ovf, out_exc, out_wen};
  endfunction

  // Reference: signed/unsigned integer arithmetic on 64-bit values.
  function automatic void ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic c, output logic o,
                                  output logic t);
    longint sa, sb, ua, ub, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    c = (a < b);
    o = 1'b0;
    t = 1'b0;
    case (op)
      3'd2, 3'd3: begin
        r = a - b;
        s = sa - sb;
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        t = (op == 3'd2) && o;
      end
      3'd4: r = (sa < sb) ? 32'd1 : 32'd0;
      3'd5: r = (a < b) ? 32'd1 : 32'd0;
      default: begin
        s = ua + ub;
        r = s[31:0];
        c = s[32];
        s = sa + sb;
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        t = (op == 3'd0) && o;
      end
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc);
    in_op = op; in_a = a; in_b = b; in_pc = pc; in_rd = 5'd7; in_wen = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; exc_ack = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({obs(), out_rd, out_pc, exc_req, exc_epc, in_ready} !== {37'h0, 5'h0, 32'h0, 1'b0, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset: got out=%h rd=%h pc=%h req=%b epc=%h rdy=%b want all zero, in_ready 1",
               obs(), out_rd, out_pc, exc_req, exc_epc, in_ready);
    end
  endtask

  task automatic test_addu();
    logic [36:0] exp;
    issue(3'd1, 32'h7fffffff, 32'h80000000, 32'h10);
    exp = {1'b1, 32'hffffffff, 1'b0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL addu_basic: got %h want %h", obs(), exp); end
    issue(3'd1, 32'h80000000, 32'h80000000, 32'h14);
    exp = {1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1};
    checks++;
    if ({obs(), exc_req} !== {exp, 1'b0}) begin
      errors++; $display("FAIL addu_ovf: got %h req=%b want %h req=0", obs(), exc_req, exp);
    end
  endtask

  task automatic test_add_trap();
    logic [36:0] exp;
    issue(3'd0, 32'h7fffffff, 32'h00000001, 32'h40);
    exp = {1'b1, 32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0};
    checks++;
    if ({obs(), exc_req, exc_epc, out_pc} !== {exp, 1'b1, 32'h40, 32'h40}) begin
      errors++;
      $display("FAIL add_trap: got %h req=%b epc=%h pc=%h want %h req=1 epc=40 pc=40",
               obs(), exc_req, exc_epc, out_pc, exp);
    end
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL exc_stall[%0d]: in_ready=%b want 0", i, in_ready); end
      @(posedge clk); #1;
    end
    checks++;
    if ({out_valid, exc_req} !== 2'b01) begin
      errors++; $display("FAIL exc_hold: valid=%b req=%b want valid=0 req=1", out_valid, exc_req);
    end
    exc_ack = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL ack_cycle: in_ready=%b want 0", in_ready); end
    @(posedge clk); #1;
    exc_ack = 1'b0; #1;
    checks++;
    if ({in_ready, exc_req, out_valid} !== 3'b100) begin
      errors++; $display("FAIL exc_release: rdy/req/valid=%b want 100", {in_ready, exc_req, out_valid});
    end
    in_valid = 1'b0;
  endtask

  task automatic test_sub();
    logic [36:0] exp;
    issue(3'd3, 32'hffffffff, 32'h7fffffff, 32'h50);
    exp = {1'b1, 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL subu_a: got %h want %h", obs(), exp); end
    issue(3'd3, 32'h80000000, 32'hffffffff, 32'h54);
    exp = {1'b1, 32'h80000001, 1'b1, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL subu_b: got %h want %h", obs(), exp); end
    issue(3'd2, 32'h7fffffff, 32'h80000000, 32'h58);
    exp = {1'b1, 32'hffffffff, 1'b1, 1'b1, 1'b1, 1'b0};
    checks++;
    if ({obs(), exc_req, exc_epc} !== {exp, 1'b1, 32'h58}) begin
      errors++; $display("FAIL sub_trap: got %h req=%b epc=%h want %h req=1 epc=58", obs(), exc_req, exc_epc, exp);
    end
    exc_ack = 1'b1; @(posedge clk); #1; exc_ack = 1'b0;
  endtask

  task automatic test_slt();
    logic [36:0] exp;
    issue(3'd4, 32'h80000000, 32'h00000001, 32'h60);
    exp = {1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL slt: got %h want %h", obs(), exp); end
    issue(3'd5, 32'h80000000, 32'h00000001, 32'h64);
    exp = {1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL sltu: got %h want %h", obs(), exp); end
  endtask

  task automatic test_backpressure();
    logic [36:0] held, exp;
    issue(3'd1, 32'h10, 32'h20, 32'h70);
    held = {1'b1, 32'h30, 1'b0, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b0;
    in_op = 3'd3; in_a = 32'h100; in_b = 32'h1; in_pc = 32'h74; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({obs(), in_ready} !== {held, 1'b0}) begin
        errors++; $display("FAIL hold[%0d]: got %h rdy=%b want %h rdy=0", i, obs(), in_ready, held);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release: in_ready=%b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp = {1'b1, 32'hff, 1'b0, 1'b0, 1'b0, 1'b1};
    checks++;
    if ({obs(), out_pc} !== {exp, 32'h74}) begin
      errors++; $display("FAIL after_hold: got %h pc=%h want %h pc=74", obs(), out_pc, exp);
    end
  endtask

  task automatic test_flush();
    issue(3'd1, 32'h1, 32'h2, 32'h80);
    out_ready = 1'b0;
    in_op = 3'd1; in_a = 32'h5; in_b = 32'h6; in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_clear: out_valid=%b want 0", out_valid); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_noaccept: out_valid=%b want 0", out_valid); end
    issue(3'd0, 32'h80000000, 32'hffffffff, 32'h84);
    out_ready = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if ({out_valid, exc_req, exc_epc} !== {1'b0, 1'b1, 32'h84}) begin
      errors++; $display("FAIL flush_in_exc: valid=%b req=%b epc=%h want 0 1 84", out_valid, exc_req, exc_epc);
    end
    exc_ack = 1'b1; @(posedge clk); #1; exc_ack = 1'b0;
  endtask

  task automatic test_reset_in_exc();
    issue(3'd2, 32'h80000000, 32'h00000001, 32'h90);
    checks++;
    if (exc_req !== 1'b1) begin errors++; $display("FAIL rst_exc_setup: exc_req=%b want 1", exc_req); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b0; #1;
    checks++;
    if ({exc_req, out_valid, exc_epc, in_ready} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
      errors++; $display("FAIL rst_in_exc: req=%b valid=%b epc=%h rdy=%b want 0 0 0 1",
                         exc_req, out_valid, exc_epc, in_ready);
    end
  endtask

  task automatic test_random();
    logic        m_valid, m_exc, m_c, m_o, m_t, m_wen, exp_rdy, acc, exc_was;
    logic [31:0] m_res, m_pc, m_epc, r;
    logic [4:0]  m_rd;
    logic        c, o, t;
    do_reset();
    m_valid = 1'b0; m_exc = 1'b0; m_epc = '0;
    m_res = '0; m_c = 0; m_o = 0; m_t = 0; m_wen = 0; m_rd = '0; m_pc = '0;
    for (int n = 0; n < 400; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_op     = 3'($urandom_range(0, 7));
      in_a      = $urandom;
      in_b      = $urandom;
      in_pc     = $urandom;
      in_rd     = 5'($urandom);
      in_wen    = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      exc_ack   = m_exc && ($urandom_range(0, 1) == 1);
      #1;
      exp_rdy = !m_exc && (!m_valid || out_ready);
      checks++;
      if ({in_ready, exc_req} !== {exp_rdy, m_exc}) begin
        errors++; $display("FAIL rnd_ready[%0d]: rdy=%b req=%b want %b %b", n, in_ready, exc_req, exp_rdy, m_exc);
      end
      acc = in_valid && exp_rdy && !flush;
      ref_alu(in_op, in_a, in_b, r, c, o, t);
      exc_was = m_exc;
      @(posedge clk); #1;
      if (acc) begin
        m_valid = 1'b1; m_res = r; m_c = c; m_o = o && (in_op < 3'd4 || in_op > 3'd5);
        m_t = t; m_wen = in_wen && !t; m_rd = in_rd; m_pc = in_pc;
        if (t) begin m_exc = 1'b1; m_epc = in_pc; end
      end else if (flush || out_ready) begin
        m_valid = 1'b0;
      end
      if (exc_was && exc_ack) m_exc = 1'b0;
      checks++;
      if (out_valid !== m_valid || exc_epc !== m_epc ||
          (m_valid && {out_result, out_carry, out_ovf, out_exc, out_wen, out_rd, out_pc} !==
                      {m_res, m_c, m_o, m_t, m_wen, m_rd, m_pc})) begin
        errors++;
        $display("FAIL rnd_out[%0d]: got v=%b r=%h c=%b o=%b e=%b w=%b rd=%h pc=%h epc=%h want v=%b r=%h c=%b o=%b e=%b w=%b rd=%h pc=%h epc=%h",
                 n, out_valid, out_result, out_carry, out_ovf, out_exc, out_wen, out_rd, out_pc, exc_epc,
                 m_valid, m_res, m_c, m_o, m_t, m_wen, m_rd, m_pc, m_epc);
      end
    end
    in_valid = 1'b0; flush = 1'b0; exc_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; exc_ack = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_pc = '0; in_rd = '0; in_wen = 1'b0;
    test_reset();
    test_addu();
    test_add_trap();
    test_sub();
    test_slt();
    test_backpressure();
    test_flush();
    test_reset_in_exc();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
